// File: rtl/count_bcd_display.sv
// Binary-to-BCD display stage: sequential double-dabble conversion feeding a multiplexed
// active-low seven-segment scan. Optional macro: LEADING_ZERO_BLANK_EN.
module count_bcd_display #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned REFRESH = 50000
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      Count,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic                  Valid,
  output logic [6:0]            Seg,
  output logic [DIGITS-1:0]     An
);

  localparam int unsigned RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [RW-1:0] RefLast  = RW'(REFRESH - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] IterLast = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StStart, StIdle, StConv, StLoad} state_e;

  state_e                state_q;
  logic [WIDTH-1:0]      cap_q;
  logic [WIDTH-1:0]      bin_q;
  logic [4*DIGITS-1:0]   scr_q;
  logic [4*DIGITS-1:0]   scr_adj;
  logic [CW-1:0]         iter_q;
  logic [RW-1:0]         ref_q;
  logic [IW-1:0]         idx_q;
  logic [3:0]            nib;
  logic                  blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Add-3 correction applied to every scratch nibble before the shift.
  always_comb begin
    scr_adj = scr_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scr_q[4*k+:4] >= 4'd5) scr_adj[4*k+:4] = scr_q[4*k+:4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StStart;
      cap_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      iter_q  <= '0;
      Bcd     <= '0;
      Valid   <= 1'b0;
    end else begin
      case (state_q)
        StStart: begin
          cap_q   <= Count;
          bin_q   <= Count;
          scr_q   <= '0;
          iter_q  <= '0;
          state_q <= StConv;
        end
        StIdle: begin
          if (Count != cap_q) begin
            cap_q   <= Count;
            bin_q   <= Count;
            scr_q   <= '0;
            iter_q  <= '0;
            Valid   <= 1'b0;
            state_q <= StConv;
          end
        end
        StConv: begin
          {scr_q, bin_q} <= {scr_adj[4*DIGITS-2:0], bin_q, 1'b0};
          iter_q         <= iter_q + 1'b1;
          if (iter_q == IterLast) state_q <= StLoad;
        end
        StLoad: begin
          Bcd     <= scr_q;
          Valid   <= (Count == cap_q);
          state_q <= StIdle;
        end
        default: state_q <= StStart;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q <= '0;
      idx_q <= '0;
    end else if (ref_q == RefLast) begin
      ref_q <= '0;
      idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  assign nib = Bcd[4*idx_q+:4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;  // lz[k]: digit k and every higher digit are zero

  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (Bcd[4*DIGITS-1-:4] == 4'd0);
    for (int k = int'(DIGITS) - 2; k >= 0; k--) begin
      lz[k] = lz[k+1] && (Bcd[4*k+:4] == 4'd0);
    end
  end

  assign blank = (idx_q != '0) && lz[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Seg <= 7'h7F;
      An  <= '1;
    end else begin
      Seg <= blank ? 7'h7F : seg_decode(nib);
      An  <= ~(DIGITS'(1) << idx_q);
    end
  end

endmodule
